cbfp_block_exp: RTL and testbench
=================================

# cbfp_block_exp

Parametrised, pipelined block-exponent detector for the CBFP stage of the FFT datapath. It accepts LANES complex samples per beat and reduces each sample to a magnitude index without a negation adder. The per-beat maximum is accumulated over a block of BLOCK_LEN samples, and the block's maximum index plus the right-shift needed to fit OUT_WIDTH are emitted one cycle after the last beat's lane stage. It sits between a butterfly stage output and the CBFP shifter/reorder buffer.

## Interface
- DATA_WIDTH, 23, signed input width per real/imag component
- LANES, 16, complex samples per beat
- BLOCK_LEN, 64, samples per CBFP block; must be a multiple of LANES (BEATS = BLOCK_LEN/LANES ≥ 1)
- OUT_WIDTH, 16, target signed width after CBFP scaling
- MAG_WIDTH, $clog2(DATA_WIDTH), width of magnitude index
- clk  in  1  clock, rising edge
- rstn  in  1  asynchronous active-low reset
- in_valid  in  1  beat qualifier
- in_sop  in  1  first beat of a block; valid only with in_valid
- din_re / din_im  in  [LANES] x DATA_WIDTH signed  component data
- out_valid  out  1  one-cycle pulse: block result valid
- blk_mag  out  MAG_WIDTH  maximum magnitude index over the block
- blk_shift  out  MAG_WIDTH  right shift to fit OUT_WIDTH
- blk_zero  out  1  every sample in the block was 0 or -1
- err_sop  out  1  one-cycle pulse: in_sop arrived mid-block

## Operation
- Component index: mag(x) is the position of the highest set bit of (x XOR {DATA_WIDTH{x[MSB]}}) in bits DATA_WIDTH-2..0, or 0 if none. Consequences: 0 → 0, -1 → 0, 1 → 0, 2 → 1, max positive → DATA_WIDTH-2, most negative → DATA_WIDTH-2.
- Sample index = max(mag(re), mag(im)). Beat index = max over LANES samples.
- Nonzero flag per beat = OR over lanes of any differing bit. blk_zero = NOR over the block.
- blk_shift = max(0, blk_mag + 2 - OUT_WIDTH). Computed in MAG_WIDTH+1 bits, then clamped.
- Beat counter 0..BEATS-1:
  - Counts accepted beats only; holds when in_valid=0. Gaps between beats are allowed.
  - in_valid with in_sop loads the counter with 1 and starts a new accumulation (discarding any partial block).
  - in_valid without in_sop at count 0 is accepted as an implicit block start.
- Block completes on the beat at count BEATS-1. The counter wraps to 0. The result is emitted.
- in_sop while count ≠ 0: pulse err_sop, drop the partial block (no out_valid for it), start a new block with this beat.
- BEATS = 1: every valid beat is a complete block. in_sop never errors.

## Timing
- Stage 1 (registered): per-beat max index, nonzero flag, and block-end tag. Registered in cycle T+1 for a beat sampled at edge T.
- Stage 2 (registered): accumulator and output registers. out_valid is high for exactly one cycle, in T+2, where T is the last beat.
- Back-to-back blocks at full rate: no bubble. The first beat of the next block re-seeds the accumulator in the same cycle the previous result is registered.
- blk_mag, blk_shift, and blk_zero hold their last value between pulses.
- err_sop is high in T+1 for an offending beat at T.
- Reset values: out_valid=0, err_sop=0, blk_mag=0, blk_shift=0, blk_zero=1. Counter, accumulator, and stage-1 tags are all cleared.
- Reset asserted mid-block discards all in-flight beats. No out_valid is produced for them after release.

## Structure
- Package cbfp_pkg holds:
  - the mag_t typedef
  - the shift-calculation function
  - the default constants (DATA_WIDTH=23, OUT_WIDTH=16)
- Sub-module cbfp_lzc: combinational, one component → MAG_WIDTH index plus nonzero flag. Instantiated 2*LANES times.
- Lane max tree, counter, and accumulator live in the top module.

## Test plan
- Defaults, one block of 4 beats, all zeros except lane 5 of beat 2 with re=0x100000 (2^20) → out_valid in T+2 with blk_mag=20, blk_shift=6, blk_zero=0.
- Beat with im = most negative (-2^22) → blk_mag=21, blk_shift=7. All samples -1 → blk_mag=0, blk_shift=0, blk_zero=1.
- Two blocks back-to-back at full rate with maxima 15 then 9 → two out_valid pulses 4 cycles apart with values 15/1 then 9/0. No cross-contamination.
- in_sop on the 3rd beat of a block → err_sop pulse. The first block produces no result. The restarted block completes 4 accepted beats later.
- in_valid gaps of random length inside a block → result identical to the gap-free case. rstn pulsed after beat 2 → no out_valid. All outputs return to reset values.
- BEATS=1 build (BLOCK_LEN=16) → one out_valid per valid beat, latency 2.

Source files
------------

// File: rtl/cbfp_pkg.sv
// Shared constants, types and the shift rule for the CBFP block-exponent detector.
package cbfp_pkg;

    localparam int DEF_DATA_WIDTH = 23;
    localparam int DEF_OUT_WIDTH  = 16;
    localparam int DEF_MAG_WIDTH  = $clog2(DEF_DATA_WIDTH);

    typedef logic [DEF_MAG_WIDTH-1:0] mag_t;

    // Right shift that brings a block with magnitude index mag into out_width signed bits.
    function automatic int calc_shift(input int mag, input int out_width);
        return (mag + 2 > out_width) ? (mag + 2 - out_width) : 0;
    endfunction

endpackage

// File: rtl/cbfp_block_exp_if.sv
// Beat input and block-result bundle between a butterfly stage and the CBFP detector.
interface cbfp_block_exp_if
    import cbfp_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int LANES      = 16,
    parameter int MAG_WIDTH  = $clog2(DATA_WIDTH)
);
    logic                              in_valid;
    logic                              in_sop;
    logic [LANES-1:0][DATA_WIDTH-1:0]  din_re;
    logic [LANES-1:0][DATA_WIDTH-1:0]  din_im;
    logic                              out_valid;
    logic [MAG_WIDTH-1:0]              blk_mag;
    logic [MAG_WIDTH-1:0]              blk_shift;
    logic                              blk_zero;
    logic                              err_sop;

    modport master (
        output in_valid, in_sop, din_re, din_im,
        input  out_valid, blk_mag, blk_shift, blk_zero, err_sop
    );

    modport slave (
        input  in_valid, in_sop, din_re, din_im,
        output out_valid, blk_mag, blk_shift, blk_zero, err_sop
    );

endinterface

// File: rtl/cbfp_lzc.sv
// Magnitude index of one signed component: top differing bit below the sign, no negation adder.
module cbfp_lzc
    import cbfp_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int MAG_WIDTH  = $clog2(DATA_WIDTH)
) (
    input  logic [DATA_WIDTH-1:0] x,
    output logic [MAG_WIDTH-1:0]  mag,
    output logic                  nz
);

    logic [DATA_WIDTH-2:0] diff;

    // NOTE: every signal driven here gets a default before any conditional, so no latch is inferred.
    always_comb begin
        diff = x[DATA_WIDTH-2:0] ^ {(DATA_WIDTH-1){x[DATA_WIDTH-1]}};
        nz   = |diff;
        mag  = '0;
        for (int i = 0; i < DATA_WIDTH - 1; i++) begin
            if (diff[i]) mag = MAG_WIDTH'(i);
        end
    end

endmodule

// File: rtl/cbfp_block_exp.sv
// Pipelined block-exponent detector: lane max tree + beat counter (stage 1), block accumulator
// and result registers (stage 2).
module cbfp_block_exp
    import cbfp_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int LANES      = 16,
    parameter int BLOCK_LEN  = 64,
    parameter int OUT_WIDTH  = DEF_OUT_WIDTH,
    parameter int MAG_WIDTH  = $clog2(DATA_WIDTH)
) (
    input logic             clk,
    input logic             rstn,
    cbfp_block_exp_if.slave bus
);

    localparam int BEATS = BLOCK_LEN / LANES;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

    logic [MAG_WIDTH-1:0] re_mag [LANES];
    logic [MAG_WIDTH-1:0] im_mag [LANES];
    logic [LANES-1:0]     re_nz;
    logic [LANES-1:0]     im_nz;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        cbfp_lzc #(.DATA_WIDTH(DATA_WIDTH), .MAG_WIDTH(MAG_WIDTH)) u_re (
            .x(bus.din_re[i]), .mag(re_mag[i]), .nz(re_nz[i])
        );
        cbfp_lzc #(.DATA_WIDTH(DATA_WIDTH), .MAG_WIDTH(MAG_WIDTH)) u_im (
            .x(bus.din_im[i]), .mag(im_mag[i]), .nz(im_nz[i])
        );
    end

    logic [MAG_WIDTH-1:0] beat_mag;
    logic                 beat_nz;

    always_comb begin
        beat_mag = '0;
        for (int i = 0; i < LANES; i++) begin
            if (re_mag[i] > beat_mag) beat_mag = re_mag[i];
            if (im_mag[i] > beat_mag) beat_mag = im_mag[i];
        end
        beat_nz = |{re_nz, im_nz};
    end

    // An sop or a zero count starts a block; pos is where this beat lands in it.
    logic [CNT_W-1:0] cnt, pos, cnt_next;
    logic             blk_start, beat_last, sop_err;

    always_comb begin
        blk_start = bus.in_sop || (cnt == '0);
        pos       = blk_start ? '0 : cnt;
        beat_last = (pos == LAST_CNT);
        cnt_next  = beat_last ? '0 : pos + CNT_W'(1);
        sop_err   = bus.in_valid && bus.in_sop && (cnt != '0);
    end

    logic                 s1_valid, s1_first, s1_last, s1_nz, err_q;
    logic [MAG_WIDTH-1:0] s1_mag;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt      <= '0;
            s1_valid <= 1'b0;
            s1_first <= 1'b0;
            s1_last  <= 1'b0;
            s1_nz    <= 1'b0;
            s1_mag   <= '0;
            err_q    <= 1'b0;
        end else begin
            s1_valid <= bus.in_valid;
            err_q    <= sop_err;
            if (bus.in_valid) begin
                cnt      <= cnt_next;
                s1_first <= blk_start;
                s1_last  <= beat_last;
                s1_mag   <= beat_mag;
                s1_nz    <= beat_nz;
            end
        end
    end

    // A first beat ignores the accumulator, which is how partial blocks are dropped.
    logic [MAG_WIDTH-1:0] acc_mag, merged_mag, merged_shift;
    logic                 acc_nz, merged_nz;

    always_comb begin
        merged_mag   = (s1_first || (s1_mag > acc_mag)) ? s1_mag : acc_mag;
        merged_nz    = s1_nz || (!s1_first && acc_nz);
        merged_shift = MAG_WIDTH'(calc_shift(int'(merged_mag), OUT_WIDTH));
    end

    logic                 out_valid_q, blk_zero_q;
    logic [MAG_WIDTH-1:0] blk_mag_q, blk_shift_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            acc_mag     <= '0;
            acc_nz      <= 1'b0;
            out_valid_q <= 1'b0;
            blk_mag_q   <= '0;
            blk_shift_q <= '0;
            blk_zero_q  <= 1'b1;
        end else begin
            out_valid_q <= s1_valid && s1_last;
            if (s1_valid) begin
                acc_mag <= merged_mag;
                acc_nz  <= merged_nz;
            end
            if (s1_valid && s1_last) begin
                blk_mag_q   <= merged_mag;
                blk_shift_q <= merged_shift;
                blk_zero_q  <= !merged_nz;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.blk_mag   = blk_mag_q;
    assign bus.blk_shift = blk_shift_q;
    assign bus.blk_zero  = blk_zero_q;
    assign bus.err_sop   = err_q;

endmodule

// File: tb/tb_cbfp_block_exp.sv
// Randomised bench for cbfp_block_exp: a 4-beat build and a 1-beat build checked against a
// block-level reference model.
module tb_cbfp_block_exp;
    import cbfp_pkg::*;

    localparam int DW    = DEF_DATA_WIDTH;
    localparam int LANES = 16;
    localparam int OW    = DEF_OUT_WIDTH;
    localparam int MW    = DEF_MAG_WIDTH;

    typedef logic [LANES-1:0][DW-1:0] beat_t;

    typedef struct packed {
        logic valid;
        mag_t mag;
        mag_t shift;
        logic zero;
        logic err;
    } out_t;

    typedef struct {
        bit    v;
        bit    sop;
        beat_t re;
        beat_t im;
    } beat_s;

    // Block-level model: samples of the open block are reduced as they arrive.
    typedef struct {
        int beats;
        int count;
        int mx;
        bit nz;
        int hold_mag;
        int hold_shift;
        bit hold_zero;
        bit pend;
        int pend_mag;
        int pend_shift;
        bit pend_zero;
    } model_t;

    logic clk;
    logic rstn;
    int   vectors     = 0;
    int   miscompares = 0;

    model_t m0, m1;
    out_t   e0, e1, o0, o1;

    cbfp_block_exp_if #(.DATA_WIDTH(DW), .LANES(LANES), .MAG_WIDTH(MW)) bus0 ();
    cbfp_block_exp_if #(.DATA_WIDTH(DW), .LANES(LANES), .MAG_WIDTH(MW)) bus1 ();

    cbfp_block_exp #(
        .DATA_WIDTH(DW), .LANES(LANES), .BLOCK_LEN(64), .OUT_WIDTH(OW), .MAG_WIDTH(MW)
    ) dut (
        .clk(clk), .rstn(rstn), .bus(bus0)
    );

    cbfp_block_exp #(
        .DATA_WIDTH(DW), .LANES(LANES), .BLOCK_LEN(16), .OUT_WIDTH(OW), .MAG_WIDTH(MW)
    ) dut1 (
        .clk(clk), .rstn(rstn), .bus(bus1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // floor(log2) of the one's-complement magnitude, straight from the signed value.
    function automatic int ref_mag(input logic [DW-1:0] x);
        longint v;
        int     m;
        v = longint'($signed(x));
        if (v < 0) v = -v - 1;
        m = 0;
        while (v > 1) begin
            v = v >> 1;
            m++;
        end
        return m;
    endfunction

    function automatic logic [DW-1:0] rand_comp(input int maxmag);
        int          w;
        logic [DW-1:0] r;
        w = $urandom_range(0, maxmag + 1);
        r = DW'($urandom & ((32'd1 << w) - 32'd1));
        if ($urandom_range(0, 1) == 1) r = ~r;
        return r;
    endfunction

    function automatic beat_t rand_beat();
        beat_t b;
        int    mm;
        mm = $urandom_range(0, DW - 2);
        for (int i = 0; i < LANES; i++) b[i] = rand_comp(mm);
        return b;
    endfunction

    function automatic beat_s mk(input bit v, input bit sop, input beat_t re, input beat_t im);
        beat_s s;
        s.v   = v;
        s.sop = sop;
        s.re  = re;
        s.im  = im;
        return s;
    endfunction

    function automatic out_t reset_out();
        out_t r;
        r.valid = 1'b0;
        r.mag   = '0;
        r.shift = '0;
        r.zero  = 1'b1;
        r.err   = 1'b0;
        return r;
    endfunction

    function automatic string fmt(input out_t o);
        return $sformatf("v=%0b mag=%0d sh=%0d z=%0b err=%0b", o.valid, o.mag, o.shift, o.zero, o.err);
    endfunction

    task automatic model_reset(inout model_t m);
        m.count      = 0;
        m.mx         = 0;
        m.nz         = 0;
        m.hold_mag   = 0;
        m.hold_shift = 0;
        m.hold_zero  = 1;
        m.pend       = 0;
    endtask

    // Expected outputs seen one half-cycle after this beat's clock edge.
    task automatic model_beat(inout model_t m, input bit v, input bit sop,
                              input beat_t re, input beat_t im, output out_t e);
        bit err  = 0;
        bit done = 0;
        e.valid = m.pend;
        if (m.pend) begin
            m.hold_mag   = m.pend_mag;
            m.hold_shift = m.pend_shift;
            m.hold_zero  = m.pend_zero;
        end
        e.mag   = mag_t'(m.hold_mag);
        e.shift = mag_t'(m.hold_shift);
        e.zero  = m.hold_zero;
        if (v) begin
            if (sop && m.count != 0) err = 1;
            if (sop) m.count = 0;
            if (m.count == 0) begin
                m.mx = 0;
                m.nz = 0;
            end
            for (int i = 0; i < LANES; i++) begin
                if (ref_mag(re[i]) > m.mx) m.mx = ref_mag(re[i]);
                if (ref_mag(im[i]) > m.mx) m.mx = ref_mag(im[i]);
                if (re[i] != '0 && re[i] != '1) m.nz = 1;
                if (im[i] != '0 && im[i] != '1) m.nz = 1;
            end
            m.count++;
            if (m.count == m.beats) begin
                done    = 1;
                m.count = 0;
            end
        end
        e.err        = err;
        m.pend       = done;
        m.pend_mag   = m.mx;
        m.pend_shift = (m.mx + 2 > OW) ? m.mx + 2 - OW : 0;
        m.pend_zero  = !m.nz;
    endtask

    task automatic sample_outputs();
        o0 = {bus0.out_valid, bus0.blk_mag, bus0.blk_shift, bus0.blk_zero, bus0.err_sop};
        o1 = {bus1.out_valid, bus1.blk_mag, bus1.blk_shift, bus1.blk_zero, bus1.err_sop};
    endtask

    task automatic drive_idle();
        bus0.in_valid = 1'b0;
        bus0.in_sop   = 1'b0;
        bus0.din_re   = '0;
        bus0.din_im   = '0;
        bus1.in_valid = 1'b0;
        bus1.in_sop   = 1'b0;
        bus1.din_re   = '0;
        bus1.din_im   = '0;
    endtask

    // Both builds see the same beat; called at a falling edge, returns at the next one.
    task automatic apply(input bit v, input bit sop, input beat_t re, input beat_t im);
        model_beat(m0, v, sop, re, im, e0);
        model_beat(m1, v, sop, re, im, e1);
        bus0.in_valid = v;
        bus0.in_sop   = sop;
        bus0.din_re   = re;
        bus0.din_im   = im;
        bus1.in_valid = v;
        bus1.in_sop   = sop;
        bus1.din_re   = re;
        bus1.din_im   = im;
        @(posedge clk);
        @(negedge clk);
        sample_outputs();
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        drive_idle();
        repeat (3) @(negedge clk);
        sample_outputs();
        vectors++;
        if (o0 !== reset_out()) begin
            miscompares++;
            $display("FAIL reset dut: got %s, expected %s", fmt(o0), fmt(reset_out()));
        end
        vectors++;
        if (o1 !== reset_out()) begin
            miscompares++;
            $display("FAIL reset dut1: got %s, expected %s", fmt(o1), fmt(reset_out()));
        end
        rstn = 1'b1;
        model_reset(m0);
        model_reset(m1);
    endtask

    task automatic test_single_block();
        beat_s q[$];
        beat_t re;
        int    pulses = 0;
        for (int b = 0; b < 4; b++) begin
            re = '0;
            if (b == 2) re[5] = 23'h100000;
            q.push_back(mk(1'b1, b == 0, re, '0));
        end
        repeat (2) q.push_back(mk(1'b0, 1'b0, '0, '0));
        foreach (q[k]) begin
            apply(q[k].v, q[k].sop, q[k].re, q[k].im);
            vectors++;
            if (o0 !== e0) begin
                miscompares++;
                $display("FAIL single_block step %0d: got %s, expected %s", k, fmt(o0), fmt(e0));
            end
            if (o0.valid) begin
                pulses++;
                vectors++;
                if ({o0.mag, o0.shift, o0.zero} !== {mag_t'(20), mag_t'(6), 1'b0} || k != 4) begin
                    miscompares++;
                    $display("FAIL single_block value step %0d: got %s, expected mag=20 sh=6 z=0 at step 4",
                             k, fmt(o0));
                end
            end
        end
        vectors++;
        if (pulses != 1) begin
            miscompares++;
            $display("FAIL single_block pulses: got %0d, expected 1", pulses);
        end
    endtask

    task automatic test_extremes();
        beat_s q[$];
        beat_t im;
        out_t  got[$];
        for (int b = 0; b < 4; b++) begin
            im = '0;
            if (b == 1) im[0] = 23'h400000;
            q.push_back(mk(1'b1, b == 0, '0, im));
        end
        for (int b = 0; b < 4; b++) q.push_back(mk(1'b1, b == 0, '1, '1));
        repeat (2) q.push_back(mk(1'b0, 1'b0, '0, '0));
        foreach (q[k]) begin
            apply(q[k].v, q[k].sop, q[k].re, q[k].im);
            vectors++;
            if (o0 !== e0) begin
                miscompares++;
                $display("FAIL extremes step %0d: got %s, expected %s", k, fmt(o0), fmt(e0));
            end
            if (o0.valid) got.push_back(o0);
        end
        vectors++;
        if (got.size() != 2) begin
            miscompares++;
            $display("FAIL extremes pulses: got %0d, expected 2", got.size());
        end else begin
            vectors++;
            if ({got[0].mag, got[0].shift, got[0].zero} !== {mag_t'(21), mag_t'(7), 1'b0}) begin
                miscompares++;
                $display("FAIL extremes most_negative: got %s, expected mag=21 sh=7 z=0", fmt(got[0]));
            end
            vectors++;
            if ({got[1].mag, got[1].shift, got[1].zero} !== {mag_t'(0), mag_t'(0), 1'b1}) begin
                miscompares++;
                $display("FAIL extremes all_minus_one: got %s, expected mag=0 sh=0 z=1", fmt(got[1]));
            end
        end
    endtask

    task automatic test_back_to_back();
        beat_s q[$];
        beat_t d;
        int    pk[$];
        out_t  got[$];
        for (int b = 0; b < 4; b++) begin
            d = '0;
            if (b == 0) d[3] = 23'h008000;
            q.push_back(mk(1'b1, b == 0, d, '0));
        end
        for (int b = 0; b < 4; b++) begin
            d = '0;
            if (b == 3) d[15] = 23'h000200;
            q.push_back(mk(1'b1, b == 0, '0, d));
        end
        for (int blk = 0; blk < 3; blk++)
            for (int b = 0; b < 4; b++) q.push_back(mk(1'b1, b == 0, rand_beat(), rand_beat()));
        repeat (2) q.push_back(mk(1'b0, 1'b0, '0, '0));
        foreach (q[k]) begin
            apply(q[k].v, q[k].sop, q[k].re, q[k].im);
            vectors++;
            if (o0 !== e0) begin
                miscompares++;
                $display("FAIL back_to_back step %0d: got %s, expected %s", k, fmt(o0), fmt(e0));
            end
            if (o0.valid) begin
                pk.push_back(k);
                got.push_back(o0);
            end
        end
        vectors++;
        if (pk.size() != 5) begin
            miscompares++;
            $display("FAIL back_to_back pulses: got %0d, expected 5", pk.size());
        end else begin
            for (int i = 1; i < 5; i++) begin
                vectors++;
                if (pk[i] - pk[i-1] != 4) begin
                    miscompares++;
                    $display("FAIL back_to_back spacing %0d: got %0d, expected 4", i, pk[i] - pk[i-1]);
                end
            end
            vectors++;
            if ({got[0].mag, got[0].shift, got[0].zero} !== {mag_t'(15), mag_t'(1), 1'b0}) begin
                miscompares++;
                $display("FAIL back_to_back first: got %s, expected mag=15 sh=1 z=0", fmt(got[0]));
            end
            vectors++;
            if ({got[1].mag, got[1].shift, got[1].zero} !== {mag_t'(9), mag_t'(0), 1'b0}) begin
                miscompares++;
                $display("FAIL back_to_back second: got %s, expected mag=9 sh=0 z=0", fmt(got[1]));
            end
        end
    endtask

    task automatic test_sop_error();
        beat_s q[$];
        beat_t d;
        int    errs = 0;
        int    pulses = 0;
        d = '0;
        d[0] = 23'h200000;
        q.push_back(mk(1'b1, 1'b1, d, '0));
        q.push_back(mk(1'b1, 1'b0, d, '0));
        q.push_back(mk(1'b1, 1'b1, '0, '0));
        d = '0;
        d[2] = 23'h000400;
        q.push_back(mk(1'b1, 1'b0, d, '0));
        q.push_back(mk(1'b1, 1'b0, '0, '0));
        q.push_back(mk(1'b1, 1'b0, '0, '0));
        repeat (2) q.push_back(mk(1'b0, 1'b0, '0, '0));
        foreach (q[k]) begin
            apply(q[k].v, q[k].sop, q[k].re, q[k].im);
            vectors++;
            if (o0 !== e0) begin
                miscompares++;
                $display("FAIL sop_error step %0d: got %s, expected %s", k, fmt(o0), fmt(e0));
            end
            if (o0.err) begin
                errs++;
                vectors++;
                if (k != 2) begin
                    miscompares++;
                    $display("FAIL sop_error err_step: got %0d, expected 2", k);
                end
            end
            if (o0.valid) begin
                pulses++;
                vectors++;
                if ({o0.mag, o0.shift, o0.zero} !== {mag_t'(10), mag_t'(0), 1'b0} || k != 6) begin
                    miscompares++;
                    $display("FAIL sop_error result step %0d: got %s, expected mag=10 sh=0 z=0 at step 6",
                             k, fmt(o0));
                end
            end
        end
        vectors++;
        if (errs != 1 || pulses != 1) begin
            miscompares++;
            $display("FAIL sop_error counts: got err=%0d pulses=%0d, expected 1 and 1", errs, pulses);
        end
    endtask

    task automatic test_gaps();
        for (int rep = 0; rep < 3; rep++) begin
            beat_t br[4];
            beat_t bi[4];
            beat_s q[$];
            out_t  got[2];
            for (int b = 0; b < 4; b++) begin
                br[b] = rand_beat();
                bi[b] = rand_beat();
            end
            for (int pass = 0; pass < 2; pass++) begin
                q.delete();
                for (int b = 0; b < 4; b++) begin
                    if (pass == 1)
                        repeat ($urandom_range(0, 3))
                            q.push_back(mk(1'b0, $urandom_range(0, 1) == 1, rand_beat(), rand_beat()));
                    q.push_back(mk(1'b1, b == 0, br[b], bi[b]));
                end
                q.push_back(mk(1'b0, 1'b0, '0, '0));
                foreach (q[k]) begin
                    apply(q[k].v, q[k].sop, q[k].re, q[k].im);
                    vectors++;
                    if (o0 !== e0) begin
                        miscompares++;
                        $display("FAIL gaps rep %0d pass %0d step %0d: got %s, expected %s",
                                 rep, pass, k, fmt(o0), fmt(e0));
                    end
                end
                got[pass] = o0;
            end
            vectors++;
            if (got[1] !== got[0] || got[0].valid !== 1'b1) begin
                miscompares++;
                $display("FAIL gaps rep %0d: gapped %s, expected same as gap-free %s",
                         rep, fmt(got[1]), fmt(got[0]));
            end
        end
    endtask

    task automatic test_reset_mid_block();
        beat_s q[$];
        int    pulses = 0;
        apply(1'b1, 1'b1, rand_beat(), rand_beat());
        apply(1'b1, 1'b0, rand_beat(), rand_beat());
        drive_idle();
        rstn = 1'b0;
        #1;
        sample_outputs();
        model_reset(m0);
        model_reset(m1);
        vectors++;
        if (o0 !== reset_out()) begin
            miscompares++;
            $display("FAIL reset_mid dut: got %s, expected %s", fmt(o0), fmt(reset_out()));
        end
        vectors++;
        if (o1 !== reset_out()) begin
            miscompares++;
            $display("FAIL reset_mid dut1: got %s, expected %s", fmt(o1), fmt(reset_out()));
        end
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        repeat (3) q.push_back(mk(1'b0, 1'b0, '0, '0));
        repeat (2) q.push_back(mk(1'b1, 1'b0, rand_beat(), rand_beat()));
        repeat (2) q.push_back(mk(1'b0, 1'b0, '0, '0));
        foreach (q[k]) begin
            apply(q[k].v, q[k].sop, q[k].re, q[k].im);
            vectors++;
            if (o0 !== e0) begin
                miscompares++;
                $display("FAIL reset_mid step %0d: got %s, expected %s", k, fmt(o0), fmt(e0));
            end
            if (o0.valid) pulses++;
        end
        vectors++;
        if (pulses != 0) begin
            miscompares++;
            $display("FAIL reset_mid pulses: got %0d, expected 0", pulses);
        end
    endtask

    task automatic test_beats1();
        beat_s q[$];
        int    nvalid = 0;
        int    pulses = 0;
        for (int i = 0; i < 40; i++) begin
            q.push_back(mk($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, rand_beat(), rand_beat()));
            if (q[i].v) nvalid++;
        end
        repeat (2) q.push_back(mk(1'b0, 1'b0, '0, '0));
        foreach (q[k]) begin
            apply(q[k].v, q[k].sop, q[k].re, q[k].im);
            vectors++;
            if (o1 !== e1) begin
                miscompares++;
                $display("FAIL beats1 step %0d: got %s, expected %s", k, fmt(o1), fmt(e1));
            end
            if (o1.valid) pulses++;
        end
        vectors++;
        if (pulses != nvalid) begin
            miscompares++;
            $display("FAIL beats1 pulses: got %0d, expected %0d", pulses, nvalid);
        end
    endtask

    task automatic test_random();
        beat_s q[$];
        for (int i = 0; i < 150; i++)
            q.push_back(mk($urandom_range(0, 3) != 0, $urandom_range(0, 6) == 0, rand_beat(), rand_beat()));
        repeat (2) q.push_back(mk(1'b0, 1'b0, '0, '0));
        foreach (q[k]) begin
            apply(q[k].v, q[k].sop, q[k].re, q[k].im);
            vectors++;
            if (o0 !== e0) begin
                miscompares++;
                $display("FAIL random step %0d: got %s, expected %s", k, fmt(o0), fmt(e0));
            end
        end
    endtask

    initial begin
        rstn     = 1'b0;
        m0.beats = 4;
        m1.beats = 1;
        model_reset(m0);
        model_reset(m1);
        drive_idle();
        test_reset();
        test_single_block();
        test_extremes();
        test_back_to_back();
        test_sop_error();
        test_gaps();
        test_reset_mid_block();
        test_beats1();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
